// File: rtl/dmem_wb_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_wb_bridge_pkg
// Purpose  : Shared types for the data-memory Wishbone bridge.
//            The package holds the following items:
//              - mem_req_t: the request word from the memory unit.
//              - mtrans_t: the response word.
//              - dmem_wb_state_t: the bridge state encoding.
//              - The counter width used by the optional bus watchdog.
//              - word_align(): a word-alignment helper.
// Revision : 1.0  initial release
// ============================================================================
package dmem_wb_bridge_pkg;

  // One aligned word request as produced by the execute-stage memory unit.
  typedef struct packed {
    logic [31:0] a;
    logic        we;
    logic [3:0]  be;
    logic [31:0] d;
  } mem_req_t;

  typedef logic [31:0] mtrans_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } dmem_wb_state_t;

  // Wide enough for the full legal TIMEOUT_CYCLES range (1..65535).
  localparam int unsigned C_TIMEOUT_W = 16;

  // Byte offset is meaningless on a word bus: clear address bits [1:0].
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_wb_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_wb_bridge_if
// Purpose  : Decoupled request/response channels between the memory unit
//            and the data-side bus bridge.
//   req_valid/req_ready/req_data    : request channel (mem_req_t)
//   resp_valid/resp_ready/resp_data : response channel (32-bit word)
//   modport master : memory-unit side
//   modport slave  : bridge side
// Revision : 1.0  initial release
// ============================================================================
interface dmem_wb_bridge_if;
  import dmem_wb_bridge_pkg::*;

  logic     req_valid;
  logic     req_ready;
  mem_req_t req_data;
  logic     resp_valid;
  logic     resp_ready;
  mtrans_t  resp_data;

  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_data
  );

endinterface
`default_nettype wire

// File: rtl/dmem_wb_bridge_bus_timeout.sv
`default_nettype none
// ============================================================================
// Module   : dmem_wb_bridge_bus_timeout
// Purpose  : Wait counter for a pending Wishbone transfer.
//   clk       : core clock
//   rst       : asynchronous active-low reset
//   i_clr     : hold counter at zero (bridge not in its bus phase)
//   i_en      : count one bus cycle that ended without ack/err
//   o_expired : this cycle is the TIMEOUT_CYCLES-th waiting bus cycle
// Revision : 1.0  initial release
// ============================================================================
module dmem_wb_bridge_bus_timeout
  import dmem_wb_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  // Count holds the number of waiting bus cycles already completed, so
  // expiry is flagged while the last permitted cycle is in progress.
  localparam logic [C_TIMEOUT_W-1:0] C_LAST = C_TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [C_TIMEOUT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = i_en && (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/dmem_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : dmem_wb_bridge
// Purpose  : Runs one memory-unit request at a time as a Wishbone-classic
//            single transfer and returns the read word (zero for stores).
//   clk        : core clock, rising edge
//   rst        : asynchronous active-low reset
//   mem        : request/response channels (slave modport)
//   resp_err   : response ended in bus error or timeout (qualifies valid)
//   wb_*_o     : registered Wishbone master outputs
//   wb_dat_i, wb_ack_i, wb_err_i : Wishbone slave returns
// Build option: define MILL_BUS_TIMEOUT_EN to abort a transfer after
//               TIMEOUT_CYCLES bus cycles without ack/err.
// Revision : 1.0  initial release
// ============================================================================
module dmem_wb_bridge
  import dmem_wb_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  dmem_wb_bridge_if.slave        mem,
  output logic                   resp_err,
  output logic                   wb_cyc_o,
  output logic                   wb_stb_o,
  output logic                   wb_we_o,
  output logic [31:0]            wb_adr_o,
  output logic [3:0]             wb_sel_o,
  output logic [31:0]            wb_dat_o,
  input  logic [31:0]            wb_dat_i,
  input  logic                   wb_ack_i,
  input  logic                   wb_err_i
);

  dmem_wb_state_t r_state;
  logic           w_timeout;

  // Ready depends on state alone so request valid never reaches an output
  // combinationally.
  assign mem.req_ready = (r_state == IDLE);

`ifdef MILL_BUS_TIMEOUT_EN
  if (1) begin : g_timeout
    dmem_wb_bridge_bus_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_bus_timeout (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (r_state != BUS),
      .i_en      ((r_state == BUS) && !wb_ack_i && !wb_err_i),
      .o_expired (w_timeout)
    );
  end
`else
  // No watchdog: a transfer waits for ack/err indefinitely. The expression is
  // constant false across the legal parameter range.
  assign w_timeout = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      wb_cyc_o       <= 1'b0;
      wb_stb_o       <= 1'b0;
      wb_we_o        <= 1'b0;
      wb_adr_o       <= '0;
      wb_sel_o       <= '0;
      wb_dat_o       <= '0;
      mem.resp_valid <= 1'b0;
      mem.resp_data  <= '0;
      resp_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (mem.req_valid) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= mem.req_data.we;
            wb_adr_o <= word_align(mem.req_data.a);
            wb_sel_o <= mem.req_data.be;
            wb_dat_o <= mem.req_data.d;
            r_state  <= BUS;
          end
        end

        BUS: begin
          // Error beats a simultaneous ack; a real termination beats expiry.
          if (wb_err_i || (!wb_ack_i && w_timeout)) begin
            wb_cyc_o       <= 1'b0;
            wb_stb_o       <= 1'b0;
            mem.resp_valid <= 1'b1;
            mem.resp_data  <= '0;
            resp_err       <= 1'b1;
            r_state        <= RESP;
          end else if (wb_ack_i) begin
            wb_cyc_o       <= 1'b0;
            wb_stb_o       <= 1'b0;
            mem.resp_valid <= 1'b1;
            mem.resp_data  <= wb_we_o ? '0 : wb_dat_i;
            resp_err       <= 1'b0;
            r_state        <= RESP;
          end
        end

        RESP: begin
          if (mem.resp_ready) begin
            mem.resp_valid <= 1'b0;
            r_state        <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_wb_bridge
// Purpose  : Self-checking bench for dmem_wb_bridge. A queue-based
//            transaction model predicts bus and response outputs each cycle;
//            directed scenarios add literal expectations, followed by a
//            randomized traffic phase with occasional resets.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_wb_bridge;
  import dmem_wb_bridge_pkg::*;

  localparam int unsigned C_TO = 4;
`ifdef MILL_BUS_TIMEOUT_EN
  localparam bit C_TO_EN = 1'b1;
`else
  localparam bit C_TO_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        resp_err;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  dmem_wb_bridge_if mif ();

  dmem_wb_bridge #(
    .TIMEOUT_CYCLES (C_TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem      (mif),
    .resp_err (resp_err),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_adr_o (wb_adr_o),
    .wb_sel_o (wb_sel_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  // bus_q holds the request currently on the bus, resp_q the response
  // awaiting handshake; at most one entry exists across both.
  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } resp_t;

  mem_req_t bus_q[$];
  resp_t    resp_q[$];
  int       bus_wait;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_q.delete();
      resp_q.delete();
      bus_wait = 0;
    end else if (resp_q.size() != 0) begin
      if (mif.resp_ready) void'(resp_q.pop_front());
    end else if (bus_q.size() != 0) begin
      bus_wait++;
      if (wb_err_i) begin
        resp_q.push_back({1'b1, 32'h0});
        void'(bus_q.pop_front());
      end else if (wb_ack_i) begin
        resp_q.push_back({1'b0, bus_q[0].we ? 32'h0 : wb_dat_i});
        void'(bus_q.pop_front());
      end else if (C_TO_EN && bus_wait == int'(C_TO)) begin
        resp_q.push_back({1'b1, 32'h0});
        void'(bus_q.pop_front());
      end
    end else if (mif.req_valid) begin
      mem_req_t r;
      r   = mif.req_data;
      r.a = {r.a[31:2], 2'b00};
      bus_q.push_back(r);
      bus_wait = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      chk("req_ready", 32'(mif.req_ready), 32'(bus_q.size() == 0 && resp_q.size() == 0));
      chk("cyc", 32'(wb_cyc_o), 32'(bus_q.size() != 0));
      chk("stb", 32'(wb_stb_o), 32'(bus_q.size() != 0));
      if (bus_q.size() != 0) begin
        chk("adr", wb_adr_o, bus_q[0].a);
        chk("sel", 32'(wb_sel_o), 32'(bus_q[0].be));
        chk("we", 32'(wb_we_o), 32'(bus_q[0].we));
        chk("dat_o", wb_dat_o, bus_q[0].d);
      end
      chk("resp_valid", 32'(mif.resp_valid), 32'(resp_q.size() != 0));
      if (resp_q.size() != 0) begin
        chk("resp_err", 32'(resp_err), 32'(resp_q[0].err));
        chk("resp_data", mif.resp_data, resp_q[0].data);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_req(input logic [31:0] a, input logic we, input logic [3:0] be,
                         input logic [31:0] d);
    mif.req_valid = 1'b1;
    mif.req_data  = '{a: a, we: we, be: be, d: d};
  endtask

  initial begin
    rst            = 1'b0;
    mif.req_valid  = 1'b0;
    mif.req_data   = '0;
    mif.resp_ready = 1'b0;
    wb_ack_i       = 1'b0;
    wb_err_i       = 1'b0;
    wb_dat_i       = '0;
    repeat (3) tick();
    chk_on = 1'b1;

    // Reset state
    chk("rst_cyc", 32'(wb_cyc_o), 32'h0);
    chk("rst_stb", 32'(wb_stb_o), 32'h0);
    chk("rst_we", 32'(wb_we_o), 32'h0);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_sel", 32'(wb_sel_o), 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_resp_valid", 32'(mif.resp_valid), 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'h0);
    chk("rst_resp_data", mif.resp_data, 32'h0);
    chk("rst_req_ready", 32'(mif.req_ready), 32'h1);
    rst = 1'b1;
    tick();

    // Load, zero-wait slave
    put_req(32'h1000_0006, 1'b0, 4'b1100, 32'h0);
    tick();
    chk("ld_cyc", 32'(wb_cyc_o), 32'h1);
    chk("ld_adr", wb_adr_o, 32'h1000_0004);
    chk("ld_sel", 32'(wb_sel_o), 32'hC);
    chk("ld_req_ready", 32'(mif.req_ready), 32'h0);
    mif.req_valid = 1'b0;
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hDEAD_BEEF;
    tick();
    chk("ld_resp_valid", 32'(mif.resp_valid), 32'h1);
    chk("ld_resp_data", mif.resp_data, 32'hDEAD_BEEF);
    chk("ld_resp_err", 32'(resp_err), 32'h0);
    chk("ld_cyc_drop", 32'(wb_cyc_o), 32'h0);
    wb_ack_i = 1'b0;
    mif.resp_ready = 1'b1;
    tick();
    chk("ld_done_valid", 32'(mif.resp_valid), 32'h0);
    chk("ld_done_ready", 32'(mif.req_ready), 32'h1);
    mif.resp_ready = 1'b0;

    // Store, three wait states
    put_req(32'h2000_0000, 1'b1, 4'b1111, 32'h1234_5678);
    tick();
    mif.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("st_cyc", 32'(wb_cyc_o), 32'h1);
      chk("st_we", 32'(wb_we_o), 32'h1);
      chk("st_dat", wb_dat_o, 32'h1234_5678);
      if (i == 3) wb_ack_i = 1'b1;
      tick();
    end
    wb_ack_i = 1'b0;
    chk("st_resp_valid", 32'(mif.resp_valid), 32'h1);
    chk("st_resp_data", mif.resp_data, 32'h0);
    chk("st_resp_err", 32'(resp_err), 32'h0);
    mif.resp_ready = 1'b1;
    tick();
    mif.resp_ready = 1'b0;

    // Error and ack together
    put_req(32'h3000_0010, 1'b0, 4'b1111, 32'h0);
    tick();
    mif.req_valid = 1'b0;
    wb_ack_i = 1'b1;
    wb_err_i = 1'b1;
    wb_dat_i = 32'hFFFF_FFFF;
    tick();
    chk("er_resp_err", 32'(resp_err), 32'h1);
    chk("er_resp_data", mif.resp_data, 32'h0);
    chk("er_cyc", 32'(wb_cyc_o), 32'h0);
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    mif.resp_ready = 1'b1;
    tick();
    mif.resp_ready = 1'b0;

    // Backpressure with a new request waiting
    put_req(32'h4000_0000, 1'b0, 4'b1111, 32'h0);
    tick();
    mif.req_valid = 1'b0;
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hCAFE_F00D;
    tick();
    wb_ack_i = 1'b0;
    put_req(32'h5000_0008, 1'b1, 4'b0011, 32'hA5A5_A5A5);
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", 32'(mif.resp_valid), 32'h1);
      chk("bp_resp_data", mif.resp_data, 32'hCAFE_F00D);
      chk("bp_req_ready", 32'(mif.req_ready), 32'h0);
      tick();
    end
    mif.resp_ready = 1'b1;
    tick();
    chk("bp_hs_valid", 32'(mif.resp_valid), 32'h0);
    chk("bp_hs_ready", 32'(mif.req_ready), 32'h1);
    mif.resp_ready = 1'b0;
    tick();
    chk("bp_new_cyc", 32'(wb_cyc_o), 32'h1);
    chk("bp_new_adr", wb_adr_o, 32'h5000_0008);
    chk("bp_new_sel", 32'(wb_sel_o), 32'h3);
    mif.req_valid = 1'b0;
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    mif.resp_ready = 1'b1;
    tick();
    mif.resp_ready = 1'b0;

    // Reset in the middle of a pending load
    put_req(32'h6000_0000, 1'b0, 4'b1111, 32'h0);
    tick();
    mif.req_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("mr_cyc", 32'(wb_cyc_o), 32'h0);
    chk("mr_stb", 32'(wb_stb_o), 32'h0);
    tick();
    rst = 1'b1;
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h1111_2222;
    tick();
    wb_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("mr_resp_valid", 32'(mif.resp_valid), 32'h0);
      tick();
    end

    // Slave that never answers
    put_req(32'h7000_0000, 1'b0, 4'b1111, 32'h0);
    tick();
    mif.req_valid = 1'b0;
`ifdef MILL_BUS_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      chk("to_cyc", 32'(wb_cyc_o), 32'h1);
      tick();
    end
    chk("to_resp_valid", 32'(mif.resp_valid), 32'h1);
    chk("to_resp_err", 32'(resp_err), 32'h1);
    chk("to_resp_data", mif.resp_data, 32'h0);
    chk("to_cyc_drop", 32'(wb_cyc_o), 32'h0);
`else
    repeat (99) tick();
    chk("nt_cyc", 32'(wb_cyc_o), 32'h1);
    chk("nt_resp_valid", 32'(mif.resp_valid), 32'h0);
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
`endif
    mif.resp_ready = 1'b1;
    tick();
    mif.resp_ready = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 499) != 0);
      mif.req_valid  = $urandom_range(0, 1) == 1;
      mif.req_data   = '{a: $urandom, we: 1'($urandom_range(0, 1)),
                         be: 4'($urandom_range(0, 15)), d: $urandom};
      mif.resp_ready = $urandom_range(0, 2) != 0;
      wb_ack_i       = $urandom_range(0, 3) == 0;
      wb_err_i       = $urandom_range(0, 15) == 0;
      wb_dat_i       = $urandom;
      tick();
    end
    rst = 1'b1;
    mif.req_valid = 1'b0;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    repeat (3) tick();
    chk_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_wb_bridge.md
Name: dmem_wb_bridge

Overview:
Data-side bus master directly downstream of the execute-stage memory unit. It accepts one aligned word request (a, we, be, d) on the mem_req decoupled channel and runs it as a Wishbone-classic single transfer. It returns the read word, or zero for stores, on the mem_resp decoupled channel. Strictly one transaction in flight; all bus outputs are registered.

Parameters:
TIMEOUT_CYCLES, 255, bus cycles spent waiting for ack/err before abort; used only with MILL_BUS_TIMEOUT_EN; legal range 1..65535.

Ports:
clk  in  1  core clock; all logic on rising edge
rst  in  1  reset, asynchronous, active-low
mem_req  decoupled.in  mem_req_t (a 32, we 1, be 4, d 32)  request from memory unit
mem_resp  decoupled.out  mtrans (32)  read data / store completion
resp_err  out  1  qualifies mem_resp.valid: transfer ended in bus error (or timeout)
wb_cyc_o  out  1  bus cycle
wb_stb_o  out  1  strobe
wb_we_o  out  1  write enable
wb_adr_o  out  32  word-aligned address; bits [1:0] forced 0
wb_sel_o  out  4  byte select
wb_dat_o  out  32  write data
wb_dat_i  in  32  read data
wb_ack_i  in  1  normal termination
wb_err_i  in  1  error termination

Behaviour:
- States: IDLE, BUS, RESP. Reset: state=IDLE; wb_cyc_o=wb_stb_o=wb_we_o=0; wb_adr_o, wb_sel_o, wb_dat_o=0; mem_resp.valid=0; resp_err=0; resp data=0.
- mem_req.ready = (state==IDLE), combinational from state only; no combinational path from mem_req.valid to any output.
- IDLE: on mem_req.valid && ready, latch a (a[1:0] dropped), we, be, d into the wb_* registers, set cyc=stb=1 and go to BUS. Request accepted in cycle 0 gives cyc/stb high in cycle 1.
- BUS: hold all wb_* outputs stable.
  - wb_err_i=1: drop cyc/stb next edge, resp_err=1, data=0, go to RESP.
  - else wb_ack_i=1: drop cyc/stb next edge, data = we ? 0 : wb_dat_i, resp_err=0, go to RESP.
  - err has priority over a simultaneous ack.
- RESP: mem_resp.valid=1 with data/resp_err held until mem_resp.ready. On handshake: valid=0, go to IDLE. Next request is accepted no earlier than the following cycle.
- Latency with zero-wait slave (ack in cycle 1): mem_resp.valid in cycle 2. Minimum request-to-request issue spacing is 3 cycles.
- ack/err observed in IDLE or RESP: ignored, no state change.
- Reset asserted mid-transfer: cyc/stb drop asynchronously; any pending response is discarded. Upstream must re-issue after reset.
- mem_req.data changing while in BUS/RESP has no effect (not sampled).
- Stores still produce a response beat, because the memory unit retires on mem_resp.valid.

Optional Feature:
MILL_BUS_TIMEOUT_EN
- Defined: a wait counter clears on entering BUS and increments each BUS cycle without ack/err. When it reaches TIMEOUT_CYCLES, the bridge aborts: cyc/stb drop, resp_err=1, data=0, go to RESP. If ack/err arrives in the same cycle as expiry, ack/err wins.
- Not defined: no counter is built, BUS waits indefinitely, and TIMEOUT_CYCLES is unused.

Decomposition:
- types.sv gains mem_req_t (if not already shared with the memory unit) and the enum dmem_wb_state_t {IDLE, BUS, RESP}.
- Sub-module bus_timeout (counter, clear/enable in, expired out) is instantiated only under MILL_BUS_TIMEOUT_EN.

Test Plan:
- Load, zero-wait: req a=0x1000_0006, we=0, be=4'b1100; ack in cycle 1 with dat_i=0xDEAD_BEEF -> wb_adr_o=0x1000_0004, sel=4'b1100 in cycle 1; mem_resp data=0xDEAD_BEEF, resp_err=0, valid in cycle 2.
- Store, 3 wait states: a=0x2000_0000, we=1, be=4'b1111, d=0x1234_5678 -> cyc/stb/we/dat held stable for 4 cycles; resp data=0, resp_err=0 one cycle after ack.
- Error: ack=1 and err=1 in the same cycle -> resp_err=1, data=0; cyc drops on the next edge.
- Backpressure: mem_resp.ready=0 for 5 cycles while mem_req.valid=1 with a new request -> resp held stable; mem_req.ready=0 throughout; new request accepted the cycle after the resp handshake.
- Reset mid-BUS: rst low in cycle 2 of a pending load -> cyc/stb=0 immediately; after release, late ack is ignored and mem_resp.valid stays 0.
- Timeout (macro on, TIMEOUT_CYCLES=4): no ack -> abort after 4 BUS cycles with resp_err=1. Macro off: still waiting at cycle 100.
